// File: rtl/rsp_rr_arbiter_pkg.sv
// Shared types and helpers for the read-response return-path arbiter.
// Consumed by rsp_rr_arbiter and rr_pick via import rsp_arb_pkg::*.
package rsp_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } state_t;

    localparam int MAX_SW_INST = 16;
    localparam int OPID_NONE   = 0;

    // Wide one-hot; callers size-cast down to their instance count.
    function automatic logic [MAX_SW_INST-1:0] onehot(input int unsigned idx);
        onehot = MAX_SW_INST'(1) << idx;
    endfunction

endpackage

// File: rtl/rsp_rr_arbiter_pick.sv
// rr_pick: combinational rotating-priority encoder.
// Returns the first set bit of eligible scanning from ptr upward with wrap.
module rr_pick
    import rsp_arb_pkg::*;
#(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rsp_rr_arbiter.sv
// Round-robin arbiter sharing one registered read-response path between switch instances.
// Define RSP_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotation pointer).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | sample eligible requests, capture the winner's payload
//   ARB_HOLD | response presented on outputs until valid && ready
module rsp_rr_arbiter
    import rsp_arb_pkg::*;
#(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int OPID_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SW_INST-1:0] req,
    input  logic [W_WIDTH-1:0]     rd_data_in [NUM_SW_INST],
    input  logic [OPID_W-1:0]      op_id_in   [NUM_SW_INST],
    output logic [NUM_SW_INST-1:0] grant,
    output logic [W_WIDTH-1:0]     rd_data_out,
    output logic [OPID_W-1:0]      op_id_out,
    output logic                   valid,
    input  logic                   ready
);

    localparam int IDX_W = $clog2(NUM_SW_INST);

    state_t                 state;
    logic [NUM_SW_INST-1:0] eligible;
    logic [IDX_W-1:0]       pick_ptr;
    logic [IDX_W-1:0]       winner;
    logic                   found;
    logic                   capture;

    // A zero op_id marks an empty slot, so such requests are never granted.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            eligible[i] = req[i] && (op_id_in[i] != OPID_W'(OPID_NONE));
        end
    end

    assign capture = (state == ARB_IDLE) && found;

`ifdef RSP_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (capture) begin
            ptr <= (winner == IDX_W'(NUM_SW_INST - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    assign pick_ptr = ptr;
`endif

    rr_pick #(
        .N     (NUM_SW_INST),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (pick_ptr),
        .winner   (winner),
        .found    (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            valid       <= 1'b0;
            rd_data_out <= '0;
            op_id_out   <= '0;
        end else begin
            grant <= '0;
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        rd_data_out <= rd_data_in[winner];
                        op_id_out   <= op_id_in[winner];
                        valid       <= 1'b1;
                        grant       <= NUM_SW_INST'(onehot(32'(winner)));
                        state       <= ARB_HOLD;
                    end else begin
                        valid <= 1'b0;
                    end
                end
                ARB_HOLD: begin
                    if (valid && ready) begin
                        valid <= 1'b0;
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    a_grant_with_valid: assert property (@(posedge clk) disable iff (rst)
        (|grant) |-> (valid && $onehot(grant)));

endmodule

// File: tb/tb_rsp_rr_arbiter.sv
// Directed self-checking bench for rsp_rr_arbiter (NUM_SW_INST=5, 8-bit data/op_id).
module tb_rsp_rr_arbiter;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [7:0]   rd_data_in [N];
    logic [7:0]   op_id_in   [N];
    logic [N-1:0] grant;
    logic [7:0]   rd_data_out;
    logic [7:0]   op_id_out;
    logic         valid;
    logic         ready;

    int checks   = 0;
    int failures = 0;

    rsp_rr_arbiter #(
        .NUM_SW_INST (N),
        .W_WIDTH     (8),
        .OPID_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rd_data_in  (rd_data_in),
        .op_id_in    (op_id_in),
        .grant       (grant),
        .rd_data_out (rd_data_out),
        .op_id_out   (op_id_out),
        .valid       (valid),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          exp_w;
    logic [N-1:0] exp_oh;

    initial begin
        rst   = 1'b1;
        req   = 5'b11111;
        ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rd_data_in[i] = 8'(8'h10 + i);
            op_id_in[i]   = 8'(i + 1);
        end

        // Reset with all requests high
        step();
        step();
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_rd", 32'(rd_data_out), 32'd0);
        check_val("rst_op", 32'(op_id_out), 32'd0);
        req = '0;
        rst = 1'b0;
        step();
        check_val("idle_valid", 32'(valid), 32'd0);

        // Single request on instance 2
        rd_data_in[2] = 8'hA5;
        op_id_in[2]   = 8'h11;
        req           = 5'b00100;
        step();
        check_val("single_valid", 32'(valid), 32'd1);
        check_val("single_rd", 32'(rd_data_out), 32'hA5);
        check_val("single_op", 32'(op_id_out), 32'h11);
        check_val("single_grant", 32'(grant), 32'b00100);
        req = '0;
        step();
        check_val("single_valid_drop", 32'(valid), 32'd0);
        check_val("single_grant_drop", 32'(grant), 32'd0);

        // Re-centre the pointer, then all five request together
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_data_in[i] = 8'(8'h10 + i);
            op_id_in[i]   = 8'(i + 1);
        end
        req   = 5'b11111;
        exp_w = 0;
        for (int r = 0; r < 6; r++) begin
            step();
`ifdef RSP_ARB_FIXED_PRIO_EN
            exp_w = 0;
`endif
            exp_oh = '0;
            exp_oh[exp_w] = 1'b1;
            check_val($sformatf("rr_grant_%0d", r), 32'(grant), 32'(exp_oh));
            check_val($sformatf("rr_rd_%0d", r), 32'(rd_data_out), 32'h10 + 32'(exp_w));
            req[exp_w] = 1'b0;
            step();
            check_val($sformatf("rr_gap_%0d", r), 32'(grant | N'(valid)), 32'd0);
            req[exp_w] = 1'b1;
            exp_w = (exp_w + 1) % N;
        end
        req = '0;

        // Backpressure: hold for 4 cycles while instance 3 waits
        rd_data_in[0] = 8'h3C;
        op_id_in[0]   = 8'h44;
        req           = 5'b00001;
        ready         = 1'b0;
        step();
        check_val("bp_valid", 32'(valid), 32'd1);
        check_val("bp_grant", 32'(grant), 32'b00001);
        req           = 5'b01000;
        rd_data_in[3] = 8'h77;
        op_id_in[3]   = 8'h55;
        for (int c = 0; c < 4; c++) begin
            step();
            check_val($sformatf("bp_hold_valid_%0d", c), 32'(valid), 32'd1);
            check_val($sformatf("bp_hold_rd_%0d", c), 32'(rd_data_out), 32'h3C);
            check_val($sformatf("bp_hold_op_%0d", c), 32'(op_id_out), 32'h44);
            check_val($sformatf("bp_hold_grant_%0d", c), 32'(grant), 32'd0);
        end
        ready = 1'b1;
        step();
        check_val("bp_release_valid", 32'(valid), 32'd0);
        check_val("bp_release_grant", 32'(grant), 32'd0);
        step();
        check_val("bp_next_grant", 32'(grant), 32'b01000);
        check_val("bp_next_rd", 32'(rd_data_out), 32'h77);
        check_val("bp_next_op", 32'(op_id_out), 32'h55);
        req = '0;
        step();
        check_val("bp_next_drop", 32'(valid), 32'd0);

        // Reserved op_id on instance 1 must never win
        op_id_in[1]   = 8'h00;
        rd_data_in[4] = 8'h99;
        op_id_in[4]   = 8'h22;
        req           = 5'b10010;
        step();
        check_val("resv_grant", 32'(grant), 32'b10000);
        check_val("resv_op", 32'(op_id_out), 32'h22);
        check_val("resv_rd", 32'(rd_data_out), 32'h99);
        req = 5'b00010;
        step();
        check_val("resv_drop", 32'(valid), 32'd0);
        step();
        check_val("resv_ignored_valid", 32'(valid), 32'd0);
        check_val("resv_ignored_grant", 32'(grant), 32'd0);
        step();
        check_val("resv_still_ignored", 32'(valid), 32'd0);
        req = '0;

        // Reset while holding a response, then pointer must restart at 0
        rd_data_in[2] = 8'hA5;
        op_id_in[2]   = 8'h11;
        req           = 5'b00100;
        ready         = 1'b0;
        step();
        check_val("mid_capture", 32'(grant), 32'b00100);
        req = '0;
        step();
        check_val("mid_hold_valid", 32'(valid), 32'd1);
        rst = 1'b1;
        step();
        check_val("mid_rst_valid", 32'(valid), 32'd0);
        check_val("mid_rst_op", 32'(op_id_out), 32'd0);
        rst           = 1'b0;
        ready         = 1'b1;
        rd_data_in[1] = 8'h31;
        op_id_in[1]   = 8'h21;
        req           = 5'b10010;
        step();
        check_val("mid_after_grant", 32'(grant), 32'b00010);
        check_val("mid_after_op", 32'(op_id_out), 32'h21);
        req = '0;
        step();
        check_val("mid_after_drop", 32'(valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
